// File: rtl/btn_debounce_multi.sv
// Per-channel button debouncer. Each channel has a 2-flop synchroniser,
// a stability counter, a debounced level, press/release pulses and an
// optional auto-repeat of the press pulse while the button stays held.
// Channels share nothing but the clock and reset.
module btn_debounce_multi #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned RPT_W         = 25
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic [N_BTN-1:0] i_btn,
    input  logic [N_BTN-1:0] i_repeat_en,
    output logic [N_BTN-1:0] o_db_btn,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_db;
        logic             w_db_nxt;
        logic             w_rise;
        logic             w_fall;
        logic             r_press;
        logic             r_release;
        rpt_state_e       r_state;
        rpt_state_e       w_state_nxt;
        logic [RPT_W-1:0] r_rpt;
        logic [RPT_W-1:0] w_rpt_nxt;
        logic             w_rpt_pulse;

        // Two-flop synchroniser for the raw pin
        always_ff @(posedge i_clk or negedge i_nrst) begin
            if (!i_nrst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= i_btn[gi];
                r_sync2 <= r_sync1;
            end
        end

        // Stability counter: accept the new level after DB_CYCLES steady cycles
        always_comb begin
            w_cnt_nxt = '0;
            w_db_nxt  = r_db;
            if (r_sync2 != r_db) begin
                if (r_cnt == CNT_LAST) begin
                    w_db_nxt = r_sync2;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_rise = w_db_nxt & ~r_db;
        assign w_fall = ~w_db_nxt & r_db;

        // Repeat FSM next state; dropping the level or the enable always returns to idle
        always_comb begin
            w_state_nxt = r_state;
            w_rpt_nxt   = r_rpt;
            w_rpt_pulse = 1'b0;
            if (!i_repeat_en[gi] || !w_db_nxt) begin
                w_state_nxt = ST_IDLE;
                w_rpt_nxt   = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            w_state_nxt = ST_DELAY;
                            w_rpt_nxt   = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (r_rpt == DLY_LAST) begin
                            w_rpt_pulse = 1'b1;
                            w_rpt_nxt   = '0;
                            w_state_nxt = ST_REPEAT;
                        end else begin
                            w_rpt_nxt = r_rpt + RPT_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (r_rpt == PER_LAST) begin
                            w_rpt_pulse = 1'b1;
                            w_rpt_nxt   = '0;
                        end else begin
                            w_rpt_nxt = r_rpt + RPT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_rpt_nxt   = '0;
                    end
                endcase
            end
        end

        // Channel state and registered outputs
        always_ff @(posedge i_clk or negedge i_nrst) begin
            if (!i_nrst) begin
                r_cnt     <= '0;
                r_db      <= 1'b0;
                r_state   <= ST_IDLE;
                r_rpt     <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_cnt     <= w_cnt_nxt;
                r_db      <= w_db_nxt;
                r_state   <= w_state_nxt;
                r_rpt     <= w_rpt_nxt;
                r_press   <= w_rise | w_rpt_pulse;
                r_release <= w_fall;
            end
        end

        assign o_db_btn[gi]  = r_db;
        assign o_press[gi]   = r_press;
        assign o_release[gi] = r_release;
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi with short debounce/repeat timing.
module tb_btn_debounce_multi;

    localparam int unsigned N_BTN         = 4;
    localparam int unsigned DB_CYCLES     = 4;
    localparam int unsigned CNT_W         = 3;
    localparam int unsigned REPEAT_DELAY  = 10;
    localparam int unsigned REPEAT_PERIOD = 5;
    localparam int unsigned RPT_W         = 4;

    logic             clk = 1'b0;
    logic             nrst;
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] repeat_en;
    logic [N_BTN-1:0] db_btn;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;

    int n_checks = 0;
    int n_fail   = 0;

    btn_debounce_multi #(
        .N_BTN        (N_BTN),
        .DB_CYCLES    (DB_CYCLES),
        .CNT_W        (CNT_W),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .RPT_W        (RPT_W)
    ) u_dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_btn      (btn),
        .i_repeat_en(repeat_en),
        .o_db_btn   (db_btn),
        .o_press    (press),
        .o_release  (rel)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst      = 1'b1;
        btn       = '0;
        repeat_en = '0;
        #2;
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({db_btn, press, rel} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", {db_btn, press, rel}, 12'h000);
        end
        repeat (3) tick();
        n_checks++;
        if ({db_btn, press, rel} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_held: got %b expected %b", {db_btn, press, rel}, 12'h000);
        end
        nrst = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_db;
        logic [3:0] exp_p;
        btn = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_db = (k == 6) ? 4'b0001 : 4'b0000;
            exp_p  = (k == 6) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (db_btn !== exp_db || press !== exp_p || rel !== 4'b0000) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: db=%b press=%b rel=%b expected db=%b press=%b rel=0000",
                         k, db_btn, press, rel, exp_db, exp_p);
            end
        end
        tick();
        n_checks++;
        if (db_btn !== 4'b0001 || press !== 4'b0000) begin
            n_fail++;
            $display("FAIL press_single_cycle: db=%b press=%b expected db=0001 press=0000", db_btn, press);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_db;
        logic [3:0] exp_p;
        for (int k = 0; k < 8; k++) begin
            btn[1] = ((k % 2) == 0);
            tick();
            n_checks++;
            if (db_btn !== 4'b0001 || press !== 4'b0000 || rel !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce toggle %0d: db=%b press=%b rel=%b expected db=0001 press=0000 rel=0000",
                         k, db_btn, press, rel);
            end
        end
        btn[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_db = (k == 6) ? 4'b0011 : 4'b0001;
            exp_p  = (k == 6) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (db_btn !== exp_db || press !== exp_p || rel !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce_hold edge %0d: db=%b press=%b rel=%b expected db=%b press=%b rel=0000",
                         k, db_btn, press, rel, exp_db, exp_p);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] exp_db;
        logic [3:0] exp_r;
        btn[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_db = (k >= 6) ? 4'b0010 : 4'b0011;
            exp_r  = (k == 6) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (db_btn !== exp_db || rel !== exp_r || press !== 4'b0000) begin
                n_fail++;
                $display("FAIL release edge %0d: db=%b rel=%b press=%b expected db=%b rel=%b press=0000",
                         k, db_btn, rel, press, exp_db, exp_r);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [3:0] exp_db;
        logic [3:0] exp_p;
        logic [3:0] exp_r;
        repeat_en = 4'b0100;
        btn[2]    = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_p = (k == 6) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (press !== exp_p) begin
                n_fail++;
                $display("FAIL repeat_accept edge %0d: press=%b expected %b", k, press, exp_p);
            end
        end
        // t counts edges after acceptance; the button is let go after t=40
        for (int t = 1; t <= 56; t++) begin
            if (t == 41) btn[2] = 1'b0;
            tick();
            exp_p  = (t >= 10 && (t % 5) == 0 && t < 46) ? 4'b0100 : 4'b0000;
            exp_r  = (t == 46) ? 4'b0100 : 4'b0000;
            exp_db = (t < 46) ? 4'b0110 : 4'b0010;
            n_checks++;
            if (press !== exp_p || rel !== exp_r || db_btn !== exp_db) begin
                n_fail++;
                $display("FAIL repeat t=%0d: press=%b rel=%b db=%b expected press=%b rel=%b db=%b",
                         t, press, rel, db_btn, exp_p, exp_r, exp_db);
            end
        end
    endtask

    task automatic test_independence();
        logic [3:0] exp_db;
        logic [3:0] exp_p;
        logic [3:0] exp_r;
        repeat_en = 4'b0000;
        btn[3]    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            btn[0] = ((k % 2) == 1);
            tick();
            exp_p  = (k == 6) ? 4'b1000 : 4'b0000;
            exp_db = (k >= 6) ? 4'b1010 : 4'b0010;
            n_checks++;
            if (press !== exp_p || db_btn !== exp_db || rel !== 4'b0000) begin
                n_fail++;
                $display("FAIL indep edge %0d: press=%b db=%b rel=%b expected press=%b db=%b rel=0000",
                         k, press, db_btn, rel, exp_p, exp_db);
            end
        end
        btn[0] = 1'b0;
        btn[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_p  = (k == 6) ? 4'b0100 : 4'b0000;
            exp_db = (k == 6) ? 4'b1110 : 4'b1010;
            n_checks++;
            if (press !== exp_p || db_btn !== exp_db || rel !== 4'b0000) begin
                n_fail++;
                $display("FAIL indep_ch2 edge %0d: press=%b db=%b rel=%b expected press=%b db=%b rel=0000",
                         k, press, db_btn, rel, exp_p, exp_db);
            end
        end
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_r  = (k == 6) ? 4'b0110 : 4'b0000;
            exp_db = (k >= 6) ? 4'b1000 : 4'b1110;
            n_checks++;
            if (rel !== exp_r || db_btn !== exp_db || press !== 4'b0000) begin
                n_fail++;
                $display("FAIL simul_release edge %0d: rel=%b db=%b press=%b expected rel=%b db=%b press=0000",
                         k, rel, db_btn, press, exp_r, exp_db);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_db;
        logic [3:0] exp_p;
        repeat_en = 4'b0100;
        btn[2]    = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_p  = (k == 6) ? 4'b0100 : 4'b0000;
            exp_db = (k >= 6) ? 4'b1100 : 4'b1000;
            n_checks++;
            if (press !== exp_p || db_btn !== exp_db) begin
                n_fail++;
                $display("FAIL mid_pre edge %0d: press=%b db=%b expected press=%b db=%b",
                         k, press, db_btn, exp_p, exp_db);
            end
        end
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({db_btn, press, rel} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %b expected %b", {db_btn, press, rel}, 12'h000);
        end
        tick();
        tick();
        nrst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_p  = (k == 6) ? 4'b1100 : 4'b0000;
            exp_db = (k == 6) ? 4'b1100 : 4'b0000;
            n_checks++;
            if (press !== exp_p || db_btn !== exp_db || rel !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_reaccept edge %0d: press=%b db=%b rel=%b expected press=%b db=%b rel=0000",
                         k, press, db_btn, rel, exp_p, exp_db);
            end
        end
        for (int t = 1; t <= 16; t++) begin
            tick();
            exp_p = (t == 10 || t == 15) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (press !== exp_p) begin
                n_fail++;
                $display("FAIL mid_repeat t=%0d: press=%b expected %b", t, press, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_auto_repeat();
        test_independence();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
